// File: rtl/s420_stim_sequencer_if.sv
// rtl/s420_stim_sequencer_if.sv - configuration slice valid/ready interface for s420_stim_sequencer
interface s420_stim_sequencer_if #(
  parameter int SLICE_W = 4
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [SLICE_W-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/s420_stim_sequencer.sv
// rtl/s420_stim_sequencer.sv - loads compare vector, drives count enable, accumulates matches
module s420_stim_sequencer #(
  parameter int C_W     = 17,
  parameter int SLICE_W = 4,
  parameter int RUN_W   = 16,
  parameter int HIT_W   = 8
) (
  input  logic                 CK,
  input  logic                 RST,
  s420_stim_sequencer_if.slave cfg,
  input  logic [RUN_W-1:0]     run_len,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 Z_in,
  output logic                 P_0,
  output logic [C_W-1:0]       C,
  output logic                 busy,
  output logic                 done,
  output logic                 hit,
  output logic [HIT_W-1:0]     hit_count
);

  localparam int NSLICE = (C_W + SLICE_W - 1) / SLICE_W;
  localparam int SH_W   = NSLICE * SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ARMED, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [SH_W-1:0]   shadow, shadow_nx, base;
  logic [IDX_W-1:0]  idx, idx_nx, cur;
  logic [RUN_W-1:0]  cnt, cnt_nx;
  logic              beat, commit, start_ok;
  int                bit_pos;

  // Next-state, shadow assembly and handshake decode; start beats a concurrent beat in ARMED
  always_comb begin
    state_nx      = state;
    shadow_nx     = shadow;
    idx_nx        = idx;
    cnt_nx        = cnt;
    commit        = 1'b0;
    start_ok      = 1'b0;
    beat          = 1'b0;
    cfg.cfg_ready = 1'b0;
    base          = shadow;
    cur           = idx;
    bit_pos       = 0;

    case (state)
      IDLE, LOAD: cfg.cfg_ready = 1'b1;
      ARMED: begin
        cfg.cfg_ready = !start;
        start_ok      = start;
      end
      default: cfg.cfg_ready = 1'b0;
    endcase

    beat = cfg.cfg_valid && cfg.cfg_ready;

    if (beat) begin
      // a beat arriving outside LOAD opens a fresh vector
      if (state != LOAD) begin
        base = '0;
        cur  = '0;
      end
      bit_pos = int'(cur) * SLICE_W;
      base[bit_pos +: SLICE_W] = cfg.cfg_data;
      shadow_nx = base;
      if (cur == IDX_W'(NSLICE - 1)) begin
        commit   = 1'b1;
        idx_nx   = '0;
        state_nx = ARMED;
      end else begin
        idx_nx   = cur + 1'b1;
        state_nx = LOAD;
      end
    end

    if (start_ok) begin
      cnt_nx   = run_len;
      state_nx = (run_len != '0) ? RUN : DONE;
    end

    if (state == RUN) begin
      cnt_nx = cnt - 1'b1;
      if (stop || cnt == RUN_W'(1)) state_nx = DONE;
    end

    if (state == DONE) state_nx = ARMED;
  end

  // State, shadow and run counter registers; C only moves on a completed load
  always_ff @(posedge CK) begin
    if (RST) begin
      state  <= IDLE;
      shadow <= '0;
      idx    <= '0;
      cnt    <= '0;
      C      <= '0;
    end else begin
      state  <= state_nx;
      shadow <= shadow_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      if (commit) C <= shadow_nx[C_W-1:0];
    end
  end

  // Registered run outputs decoded from the upcoming state
  always_ff @(posedge CK) begin
    if (RST) begin
      P_0  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      P_0  <= (state_nx == RUN);
      busy <= (state_nx == RUN);
      done <= (state_nx == DONE);
    end
  end

  // Match accumulation, cleared when a new run is accepted, saturating count
  always_ff @(posedge CK) begin
    if (RST) begin
      hit       <= 1'b0;
      hit_count <= '0;
    end else if (start_ok) begin
      hit       <= 1'b0;
      hit_count <= '0;
    end else if (P_0 && Z_in) begin
      hit <= 1'b1;
      if (hit_count != '1) hit_count <= hit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_s420_stim_sequencer.sv
// tb/tb_s420_stim_sequencer.sv - directed self-checking bench for s420_stim_sequencer
module tb_s420_stim_sequencer;

  logic        CK = 1'b0;
  logic        RST;
  logic [15:0] run_len;
  logic        start, stop, Z_in;
  logic        P_0;
  logic [16:0] C;
  logic        busy, done, hit;
  logic [7:0]  hit_count;

  int errors = 0;
  int checks = 0;

  s420_stim_sequencer_if #(.SLICE_W(4)) cfg_if ();

  s420_stim_sequencer dut (
    .CK        (CK),
    .RST       (RST),
    .cfg       (cfg_if),
    .run_len   (run_len),
    .start     (start),
    .stop      (stop),
    .Z_in      (Z_in),
    .P_0       (P_0),
    .C         (C),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .hit_count (hit_count)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CK);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] d);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = d;
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  // starts a run from ARMED and watches it until the done pulse
  task automatic do_run(input logic [15:0] rl, input int stop_at, input logic z,
                        input logic hold_cfg, output int p0cnt, output int done_at,
                        output logic rdy0);
    p0cnt   = 0;
    done_at = 0;
    start   = 1'b1;
    run_len = rl;
    Z_in    = z;
    if (hold_cfg) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = 4'hF;
    end
    #1;
    rdy0 = cfg_if.cfg_ready;
    step();
    start = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      if (P_0) p0cnt++;
      if (stop_at != 0 && P_0 && p0cnt == stop_at) stop = 1'b1;
      if (done) begin
        done_at = i;
        cfg_if.cfg_valid = 1'b0;
        break;
      end
      step();
      stop = 1'b0;
    end
    stop = 1'b0;
    Z_in = 1'b0;
    cfg_if.cfg_valid = 1'b0;
  endtask

  int   p0cnt, done_at;
  logic rdy0;

  initial begin
    RST = 1'b1;
    run_len = '0;
    start = 1'b0;
    stop = 1'b0;
    Z_in = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    step();
    step();
    chk("rst_p0", P_0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hitcnt", hit_count, 0);
    chk("rst_c", C, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    RST = 1'b0;

    // start in IDLE must be ignored
    start = 1'b1;
    run_len = 16'd5;
    step();
    start = 1'b0;
    step();
    chk("idle_start_busy", busy, 0);
    chk("idle_start_p0", P_0, 0);

    // load 0x1,0x0,0x0,0x0,0x1
    send_beat(4'h1);
    send_beat(4'h0);
    send_beat(4'h0);
    send_beat(4'h0);
    chk("c_before_commit", C, 0);
    send_beat(4'h1);
    chk("c_commit", C, 17'h10001);
    chk("armed_ready", cfg_if.cfg_ready, 1);

    // run_len=3 with Z high and cfg_valid held throughout
    do_run(16'd3, 0, 1'b1, 1'b1, p0cnt, done_at, rdy0);
    chk("conflict_ready", rdy0, 0);
    chk("run3_p0cnt", p0cnt, 3);
    chk("run3_done_at", done_at, 4);
    chk("run3_c_held", C, 17'h10001);
    chk("run3_hit", hit, 1);
    chk("run3_hitcnt", hit_count, 3);
    step();
    chk("run3_rearmed", cfg_if.cfg_ready, 1);
    chk("run3_busy_off", busy, 0);

    // run_len=0 goes straight to DONE and clears match state
    do_run(16'd0, 0, 1'b0, 1'b0, p0cnt, done_at, rdy0);
    chk("run0_p0cnt", p0cnt, 0);
    chk("run0_done_at", done_at, 1);
    chk("run0_hit", hit, 0);
    chk("run0_hitcnt", hit_count, 0);
    step();
    chk("run0_rearmed", cfg_if.cfg_ready, 1);

    // run_len=10 stopped on the 4th enable cycle
    do_run(16'd10, 4, 1'b0, 1'b0, p0cnt, done_at, rdy0);
    chk("stop_p0cnt", p0cnt, 4);
    chk("stop_done_at", done_at, 5);
    step();

    // long run saturates the match counter
    do_run(16'd300, 0, 1'b1, 1'b0, p0cnt, done_at, rdy0);
    chk("sat_p0cnt", p0cnt, 300);
    chk("sat_done_at", done_at, 301);
    chk("sat_hitcnt", hit_count, 255);
    chk("sat_hit", hit, 1);
    step();

    // reset in the middle of a run
    start = 1'b1;
    run_len = 16'd10;
    step();
    start = 1'b0;
    step();
    chk("midrun_p0", P_0, 1);
    RST = 1'b1;
    step();
    chk("midrst_p0", P_0, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_c", C, 0);
    chk("midrst_ready", cfg_if.cfg_ready, 1);
    RST = 1'b0;
    step();
    chk("midrst_stays_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
